// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RV core constants, control bundle type and opcode helper
// Purpose: opcode/funct3 encodings and the MEM/WB control bundle used by the
//          EX->MEM stage and its branch resolver.
// Ports:   none (package).
package rv_pkg;

  localparam int XLEN = 64;

  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } mem_ctrl_t;

  // Only register/immediate arithmetic can raise a meaningful overflow.
  function automatic logic is_arith(input logic [6:0] opc);
    return (opc == OPC_OP) || (opc == OPC_OP_IMM) ||
           (opc == OPC_OP_32) || (opc == OPC_OP_IMM_32);
  endfunction

endpackage

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - combinational conditional-branch decision and target
// Purpose: decides BEQ/BNE from the ALU zero flag and forms pc + (sext(imm) << 1).
// Ports:   valid_i, opcode_i, funct3_i, zero_i, pc_i, imm_i  -> instruction info
//          is_branch_o (valid conditional branch), taken_o, target_o
module branch_resolve
  import rv_pkg::*;
#(
  parameter int XLEN_P = 64,
  parameter int IMM_W  = 12
) (
  input  logic              valid_i,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic              zero_i,
  input  logic [XLEN_P-1:0] pc_i,
  input  logic [IMM_W-1:0]  imm_i,
  output logic              is_branch_o,
  output logic              taken_o,
  output logic [XLEN_P-1:0] target_o
);

  logic [XLEN_P-1:0] imm_sext;

  assign is_branch_o = valid_i && (opcode_i == OPC_BRANCH);

  always_comb begin
    taken_o = 1'b0;
    if (is_branch_o) begin
      case (funct3_i)
        F3_BEQ:  taken_o = zero_i;
        F3_BNE:  taken_o = !zero_i;
        default: taken_o = 1'b0;
      endcase
    end
  end

  // Offset is in half-word units; the add wraps modulo 2^XLEN by construction.
  assign imm_sext = {{(XLEN_P-IMM_W){imm_i[IMM_W-1]}}, imm_i};
  assign target_o = pc_i + {imm_sext[XLEN_P-2:0], 1'b0};

endmodule

// File: rtl/ex_mem_branch_stage.sv
// rtl/ex_mem_branch_stage.sv - EX->MEM pipeline register with branch resolution
// Purpose: latches ALU result/flags and MEM/WB control, resolves BEQ/BNE,
//          issues a one-cycle redirect, keeps branch statistics and sticky overflow.
// Ports:   clk, reset (async, active-high), stall_i, flush_i
//          ex_*  : EX-stage instruction, ALU outputs and control
//          mem_* : registered MEM-stage copies plus branch decision/target
//          redirect_o, ovf_sticky_o, branch_cnt_o, taken_cnt_o
module ex_mem_branch_stage
  import rv_pkg::*;
#(
  parameter int XLEN  = rv_pkg::XLEN,
  parameter int IMM_W = 12,
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             ex_valid,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [IMM_W-1:0] ex_imm,
  input  logic [6:0]       ex_opcode,
  input  logic [2:0]       ex_funct3,
  input  logic [XLEN-1:0]  ex_alu_result,
  input  logic             ex_zero_flag,
  input  logic             ex_overflow,
  input  logic [XLEN-1:0]  ex_rs2_data,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic             ex_mem_write,
  input  logic             ex_mem_to_reg,
  output logic             mem_valid,
  output logic [XLEN-1:0]  mem_alu_result,
  output logic [XLEN-1:0]  mem_rs2_data,
  output logic [REG_W-1:0] mem_rd,
  output logic             mem_reg_write,
  output logic             mem_mem_read,
  output logic             mem_mem_write,
  output logic             mem_mem_to_reg,
  output logic             mem_branch_taken,
  output logic [XLEN-1:0]  mem_branch_target,
  output logic             redirect_o,
  output logic             ovf_sticky_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] taken_cnt_o
);

  logic             valid_q;
  logic [XLEN-1:0]  alu_q;
  logic [XLEN-1:0]  rs2_q;
  logic [REG_W-1:0] rd_q;
  mem_ctrl_t        ctrl_q;
  mem_ctrl_t        ex_ctrl;
  logic             taken_q;
  logic [XLEN-1:0]  target_q;
  logic             redirect_q;
  logic             ovf_q;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q,  taken_cnt_d;

  logic             is_branch;
  logic             br_taken;
  logic [XLEN-1:0]  br_target;
  logic             ovf_set;

  branch_resolve #(
    .XLEN_P (XLEN),
    .IMM_W  (IMM_W)
  ) u_branch_resolve (
    .valid_i     (ex_valid),
    .opcode_i    (ex_opcode),
    .funct3_i    (ex_funct3),
    .zero_i      (ex_zero_flag),
    .pc_i        (ex_pc),
    .imm_i       (ex_imm),
    .is_branch_o (is_branch),
    .taken_o     (br_taken),
    .target_o    (br_target)
  );

  assign ex_ctrl = '{reg_write:  ex_reg_write,
                     mem_read:   ex_mem_read,
                     mem_write:  ex_mem_write,
                     mem_to_reg: ex_mem_to_reg};

  assign ovf_set      = ex_valid && ex_overflow && is_arith(ex_opcode);
  assign branch_cnt_d = branch_cnt_q + CNT_W'(is_branch);
  assign taken_cnt_d  = taken_cnt_q + CNT_W'(br_taken);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q      <= 1'b0;
      alu_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      ctrl_q       <= '0;
      taken_q      <= 1'b0;
      target_q     <= '0;
      redirect_q   <= 1'b0;
      ovf_q        <= 1'b0;
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else if (flush_i) begin
      // Bubble insertion wins over stall; counters and sticky are left alone.
      valid_q    <= 1'b0;
      alu_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      ctrl_q     <= '0;
      taken_q    <= 1'b0;
      target_q   <= '0;
      redirect_q <= 1'b0;
    end else if (stall_i) begin
      // Everything holds except the redirect, which must not re-fire.
      redirect_q <= 1'b0;
    end else begin
      valid_q      <= ex_valid;
      alu_q        <= ex_alu_result;
      rs2_q        <= ex_rs2_data;
      rd_q         <= ex_rd;
      ctrl_q       <= ex_ctrl;
      taken_q      <= br_taken;
      target_q     <= br_target;
      redirect_q   <= br_taken;
      ovf_q        <= ovf_q | ovf_set;
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  assign mem_valid         = valid_q;
  assign mem_alu_result    = alu_q;
  assign mem_rs2_data      = rs2_q;
  assign mem_rd            = rd_q;
  assign mem_reg_write     = ctrl_q.reg_write;
  assign mem_mem_read      = ctrl_q.mem_read;
  assign mem_mem_write     = ctrl_q.mem_write;
  assign mem_mem_to_reg    = ctrl_q.mem_to_reg;
  assign mem_branch_taken  = taken_q;
  assign mem_branch_target = target_q;
  assign redirect_o        = redirect_q;
  assign ovf_sticky_o      = ovf_q;
  assign branch_cnt_o      = branch_cnt_q;
  assign taken_cnt_o       = taken_cnt_q;

endmodule
